// File: rtl/text_pkg.sv
// Shared ASCII constants, writer states and byte classification for the UART text writer.
package text_pkg;

    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_BLANK = 8'h20;
    localparam logic [7:0] PRINT_LO  = 8'h20;
    localparam logic [7:0] PRINT_HI  = 8'h7E;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/uart_text_writer.sv
// Turns received UART bytes into character-RAM writes, tracks the cursor and
// sweeps the screen to blank on a clear strobe.
module uart_text_writer
    import text_pkg::*;
#(
    parameter int COLS  = 32,
    parameter int ROWS  = 4,
    parameter int COL_W = 5,
    parameter int ROW_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             clear,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_data,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             busy,
    output logic             drop
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_t           r_state;
    logic             r_last_cr;
    logic [ROW_W-1:0] r_cur_row;
    logic [COL_W-1:0] r_cur_col;
    logic [ROW_W-1:0] r_sw_row;
    logic [COL_W-1:0] r_sw_col;
    logic             r_wr_en;
    logic [ROW_W-1:0] r_wr_row;
    logic [COL_W-1:0] r_wr_col;
    logic [7:0]       r_wr_data;
    logic             r_busy;
    logic             r_drop;

    logic [ROW_W-1:0] w_row_inc;
    logic [ROW_W-1:0] w_adv_row;
    logic [COL_W-1:0] w_adv_col;
    logic [ROW_W-1:0] w_bk_row;
    logic [COL_W-1:0] w_bk_col;

    // Forward step, newline row and backspace step share the same wrap rules.
    always_comb begin
        w_row_inc = (r_cur_row == LAST_ROW) ? '0 : r_cur_row + ROW_W'(1);
        w_adv_col = (r_cur_col == LAST_COL) ? '0 : r_cur_col + COL_W'(1);
        w_adv_row = (r_cur_col == LAST_COL) ? w_row_inc : r_cur_row;
        w_bk_row  = r_cur_row;
        w_bk_col  = r_cur_col;
        if (r_cur_col != '0) begin
            w_bk_col = r_cur_col - COL_W'(1);
        end else if (r_cur_row != '0) begin
            w_bk_row = r_cur_row - ROW_W'(1);
            w_bk_col = LAST_COL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_last_cr <= 1'b0;
            r_cur_row <= '0;
            r_cur_col <= '0;
            r_sw_row  <= '0;
            r_sw_col  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_drop  <= 1'b0;
            if (clear) begin
                r_state  <= ST_CLEAR;
                r_sw_row <= '0;
                r_sw_col <= '0;
                r_busy   <= 1'b1;
                r_drop   <= rx_valid;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (rx_valid) begin
                            r_last_cr <= 1'b0;
                            if (is_printable(rx_data)) begin
                                r_wr_en   <= 1'b1;
                                r_wr_row  <= r_cur_row;
                                r_wr_col  <= r_cur_col;
                                r_wr_data <= rx_data;
                                r_cur_row <= w_adv_row;
                                r_cur_col <= w_adv_col;
                            end else if (rx_data == CHR_CR) begin
                                r_last_cr <= 1'b1;
                                r_cur_row <= w_row_inc;
                                r_cur_col <= '0;
                            end else if (rx_data == CHR_LF) begin
                                if (!r_last_cr) begin
                                    r_cur_row <= w_row_inc;
                                    r_cur_col <= '0;
                                end
                            end else if (rx_data == CHR_BS) begin
                                r_wr_en   <= 1'b1;
                                r_wr_row  <= w_bk_row;
                                r_wr_col  <= w_bk_col;
                                r_wr_data <= CHR_BLANK;
                                r_cur_row <= w_bk_row;
                                r_cur_col <= w_bk_col;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        r_drop    <= rx_valid;
                        r_wr_en   <= 1'b1;
                        r_wr_row  <= r_sw_row;
                        r_wr_col  <= r_sw_col;
                        r_wr_data <= CHR_BLANK;
                        if (r_sw_col == LAST_COL) begin
                            r_sw_col <= '0;
                            r_sw_row <= r_sw_row + ROW_W'(1);
                        end else begin
                            r_sw_col <= r_sw_col + COL_W'(1);
                        end
                        // Cursor is committed home only together with the final blank write.
                        if ((r_sw_row == LAST_ROW) && (r_sw_col == LAST_COL)) begin
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                            r_cur_row <= '0;
                            r_cur_col <= '0;
                            r_last_cr <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_row  = r_wr_row;
    assign wr_col  = r_wr_col;
    assign wr_data = r_wr_data;
    assign cur_row = r_cur_row;
    assign cur_col = r_cur_col;
    assign busy    = r_busy;
    assign drop    = r_drop;

endmodule

// File: tb/tb_uart_text_writer.sv
// Scoreboard bench: a linear-position text model predicts RAM writes and drops; a monitor checks them.
module tb_uart_text_writer;

    localparam int COLS = 32;
    localparam int ROWS = 4;
    localparam int N    = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       clear;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_data;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic       busy;
    logic       drop;

    uart_text_writer #(.COLS(COLS), .ROWS(ROWS), .COL_W(5), .ROW_W(2)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef struct {int row; int col; int data;} wr_t;
    wr_t wq[$];
    int  dq[$];
    int  checks = 0;
    int  errors = 0;
    int  pos = 0;
    bit  last_cr = 1'b0;
    bit  m_clear = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (reset === 1'b1) begin
            if (wr_en === 1'b1) begin
                if (wq.size() == 0) begin
                    check("unexpected_write_row_col", int'(wr_row) * COLS + int'(wr_col), -1);
                end else begin
                    e = wq.pop_front();
                    check("wr_row", int'(wr_row), e.row);
                    check("wr_col", int'(wr_col), e.col);
                    check("wr_data", int'(wr_data), e.data);
                end
            end
            if (drop === 1'b1) begin
                if (dq.size() == 0) check("unexpected_drop", 1, 0);
                else check("drop", 1, dq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int p, input int d);
        wq.push_back('{p / COLS, p % COLS, d});
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_clear) begin
            dq.push_back(1);
            return;
        end
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(pos, b);
            pos = (pos + 1) % N;
            last_cr = 1'b0;
        end else if (b == 8'h0D) begin
            pos = ((pos / COLS + 1) % ROWS) * COLS;
            last_cr = 1'b1;
        end else if (b == 8'h0A) begin
            if (!last_cr) pos = ((pos / COLS + 1) % ROWS) * COLS;
            last_cr = 1'b0;
        end else if (b == 8'h08) begin
            if (pos > 0) pos = pos - 1;
            push_wr(pos, 8'h20);
            last_cr = 1'b0;
        end else begin
            last_cr = 1'b0;
        end
    endtask

    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        model_byte(b);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic put_print(input int cnt);
        for (int i = 0; i < cnt; i++) put(8'($urandom_range(32, 126)));
    endtask

    task automatic do_clear(input bit with_rx, input logic [7:0] b);
        @(negedge clk);
        #1;
        clear = 1'b1;
        if (with_rx) begin
            rx_data  = b;
            rx_valid = 1'b1;
            dq.push_back(1);
        end
        m_clear = 1'b1;
        wq.delete();
        for (int p = 0; p < N; p++) push_wr(p, 8'h20);
        tick();
        clear    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            tick();
        end
        if (n >= 1000) check("sweep_timeout", n, 128);
        m_clear = 1'b0;
        pos     = 0;
        last_cr = 1'b0;
    endtask

    task automatic check_at(input string name, input int row, input int col);
        check({name, "_row"}, int'(cur_row), row);
        check({name, "_col"}, int'(cur_col), col);
        check({name, "_model"}, pos, row * COLS + col);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tot;
        logic [7:0] b;
        reset = 1'b0; rx_valid = 1'b0; clear = 1'b0; rx_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(drop), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_cur", int'(cur_row) * COLS + int'(cur_col), 0);
        reset = 1'b1;
        tick();

        put(8'h48); put(8'h69); tick();
        check_at("hi", 0, 2);

        do_clear(1'b0, 8'h00); wait_sweep(n); tick();
        put_print(32); tick();
        check_at("row_fill", 1, 0);
        put_print(N - 32 - 1); tick();
        check_at("last_cell", 3, 31);
        put_print(1); tick();
        check_at("screen_wrap", 0, 0);

        do_clear(1'b0, 8'h00); wait_sweep(n); tick();
        put_print(2 * COLS + 5); tick();
        check_at("pre_crlf", 2, 5);
        put(8'h0D); put(8'h0A); tick();
        check_at("crlf", 3, 0);
        put(8'h0A); tick();
        check_at("lf_wrap", 0, 0);

        do_clear(1'b0, 8'h00); wait_sweep(n); tick();
        put_print(COLS); put(8'h08); tick();
        check_at("bs_row", 0, 31);
        do_clear(1'b0, 8'h00); wait_sweep(n); tick();
        put(8'h08); tick();
        check_at("bs_home", 0, 0);

        put_print(2 * COLS + 7); tick();
        do_clear(1'b0, 8'h00);
        check_at("sweep_hold", 2, 7);
        wait_sweep(n);
        check("busy_len", n, 128);
        tick();
        check_at("sweep_home", 0, 0);

        put_print(3); tick();
        do_clear(1'b1, 8'h41);
        tot = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b1) tot++;
            if (i == 10) put(8'h42);
            else tick();
        end
        if (busy === 1'b1) tot++;
        check("pre_restart_busy", tot, 31);
        do_clear(1'b0, 8'h00);
        wait_sweep(n);
        check("restart_len", n, 128);
        check("restart_total", tot + n, 31 + 128);
        tick();
        check_at("restart_home", 0, 0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                5: b = 8'h0D;
                6: b = 8'h0A;
                7: b = 8'h08;
                8: b = 8'($urandom_range(0, 31));
                9: b = 8'($urandom_range(127, 255));
                default: b = 8'($urandom_range(32, 126));
            endcase
            put(b);
            if ($urandom_range(0, 7) == 0) tick();
        end
        tick();
        check("rand_cur", int'(cur_row) * COLS + int'(cur_col), pos);

        put_print(9); tick();
        do_clear(1'b0, 8'h00);
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_wr_en", int'(wr_en), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_drop", int'(drop), 0);
        check("mid_rst_cur", int'(cur_row) * COLS + int'(cur_col), 0);
        wq.delete(); dq.delete();
        m_clear = 1'b0; pos = 0; last_cr = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        put(8'h5A); tick(); tick();
        check_at("post_rst", 0, 1);

        repeat (3) tick();
        check("wq_empty", wq.size(), 0);
        check("dq_empty", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_text_writer.md
Name: uart_text_writer

Overview:
- Sits between the UART receiver and the dual-port character RAM that feeds the VGA text generator.
- Consumes one received byte per valid pulse, interprets printable characters and control codes (CR, LF, BS), and maintains the cursor.
- Issues single-cycle RAM write commands.
- On command, sweeps the whole screen buffer to blank.

Parameters:
COLS, 32, characters per row
ROWS, 4, text rows
COL_W, 5, column index width (>= clog2(COLS))
ROW_W, 2, row index width (>= clog2(ROWS))

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
clear  in  1  one-cycle strobe: blank screen, home cursor
wr_en  out  1  RAM write strobe
wr_row  out  ROW_W  RAM write row
wr_col  out  COL_W  RAM write column
wr_data  out  8  RAM write byte
cur_row  out  ROW_W  current cursor row
cur_col  out  COL_W  current cursor column
busy  out  1  high while clear sweep runs
drop  out  1  one-cycle pulse: byte discarded

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; cursor (0,0); state IDLE; last_was_cr=0.
- All outputs are registered.
- States: IDLE, CLEAR.
- IDLE, rx_valid=1, clear=0. The write/cursor update appears on the next cycle (latency 1).
  - Printable (0x20..0x7E):
    - wr_en=1, wr_row/wr_col = old cursor, wr_data = byte.
    - Cursor advances: col+1; at col=COLS-1, col=0 and row+1; at row=ROWS-1, row wraps to 0.
  - CR (0x0D): no write; col=0, row+1 (with wrap).
  - LF (0x0A): same as CR, except that if the previous accepted byte was CR, LF is ignored (the CR-LF pair counts as one newline).
  - BS (0x08): step back one cell, then write 0x20 at the new position.
    - col>0: col-1.
    - col=0 and row>0: row-1, col=COLS-1.
    - At (0,0): cursor stays; 0x20 written at (0,0).
  - Other codes (0x00..0x1F except the above, and 0x7F..0xFF): ignored; no write; no drop.
  - last_was_cr is set by CR and cleared by any other accepted byte.
- clear=1 (any state):
  - Enter CLEAR with sweep index 0.
  - busy=1 from the next cycle.
  - A clear during CLEAR restarts the sweep at 0.
- CLEAR:
  - One write per cycle: wr_en=1, wr_data=0x20, address row-major from (0,0) to (ROWS-1,COLS-1). Takes ROWS*COLS cycles.
  - After the final write: cursor (0,0), last_was_cr=0, busy=0, state IDLE.
- Dropping:
  - rx_valid during CLEAR → drop=1 next cycle; byte lost.
  - rx_valid and clear in the same cycle → clear wins; drop=1.
- wr_en is low in every cycle not listed above. wr_row/wr_col/wr_data hold their last values when wr_en=0.
- cur_row/cur_col always reflect the committed cursor. During CLEAR they hold the pre-clear value until sweep end.
- Back-to-back rx_valid on consecutive cycles is accepted at full rate with no bubbles.

Decomposition:
- Package text_pkg:
  - ASCII constants CHR_CR=0x0D, CHR_LF=0x0A, CHR_BS=0x08, CHR_BLANK=0x20, PRINT_LO=0x20, PRINT_HI=0x7E.
  - State encoding (IDLE, CLEAR).
- No sub-module required. Cursor next-position logic stays inline; its wrap rules are shared by the printable, newline and backspace paths.

Test Plan:
- Reset, then bytes 'H'(0x48), 'i'(0x69) → wr_en pulses writing (0,0)=0x48 then (0,1)=0x69; cursor (0,2).
- 32 printable bytes from (0,0) → last write at (0,31); cursor (1,0). At (3,31), one more byte → cursor wraps to (0,0).
- Cursor (2,5):
  - CR, LF → cursor (3,0), no wr_en, LF swallowed.
  - A further LF → (0,0).
- BS at (1,0) → cursor (0,31) with write 0x20 at (0,31). BS at (0,0) → write 0x20 at (0,0); cursor unchanged.
- clear pulse at cursor (2,7) → busy high exactly 128 cycles; 128 writes of 0x20 covering every address once; then cursor (0,0).
- clear together with rx_valid 'A', then rx_valid mid-sweep → drop pulses twice, no 'A' written. A second clear mid-sweep restarts from (0,0); total busy = cycles to restart + 128.
- Assert reset low mid-sweep → outputs 0 immediately; busy=0; cursor (0,0).
